// File: rtl/pulse_chan_arbiter.sv
// Round-robin scheduler sharing one four-phase level-flag crossing channel among NUM_REQ requesters.
// Pulse-to-chan_req latency is 2 cycles. Pulses queue in saturating per-requester counters while the channel is busy.
module pulse_chan_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_pulse,
  output logic                       chan_req,
  output logic [$clog2(NUM_REQ)-1:0] chan_id,
  input  logic                       chan_ack,
  output logic [NUM_REQ-1:0]         done_pulse,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         ovf_sticky,
  input  logic                       ovf_clr,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr, winner, ptr_nxt;
  logic [ID_W:0]      idx;
  logic               found, grant, req_nxt, terr_set, tmo_hit;
  logic [NUM_REQ-1:0] grant_vec, done_nxt, ovf_new;
  logic [TMR_W-1:0]   timer, timer_nxt;

  assign busy    = (state != IDLE);
  assign tmo_hit = TMO_EN && (timer == TMR_LAST);
  assign ptr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // First non-empty counter at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && cnt[idx[ID_W-1:0]] != '0) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    req_nxt   = 1'b0;
    done_nxt  = '0;
    timer_nxt = '0;
    terr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && found) begin
          grant     = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        req_nxt = 1'b1;
        if (chan_ack) begin
          done_nxt[chan_id] = 1'b1;
          req_nxt           = 1'b0;
          state_nxt         = REL;
        end else if (tmo_hit) begin
          terr_set  = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = REL;
        end else begin
          timer_nxt = TMO_EN ? timer + 1'b1 : '0;
        end
      end
      REL: begin
        if (!chan_ack) begin
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          terr_set  = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = TMO_EN ? timer + 1'b1 : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_vec = grant ? (NUM_REQ'(1) << winner) : '0;
    ovf_new   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ovf_new[i] = req_pulse[i] && !grant_vec[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      chan_req    <= 1'b0;
      chan_id     <= '0;
      done_pulse  <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      chan_req   <= req_nxt;
      done_pulse <= done_nxt;
      timer      <= timer_nxt;
      if (terr_set) timeout_err <= 1'b1;
      if (grant) begin
        chan_id <= winner;
        rr_ptr  <= ptr_nxt;
      end
    end
  end

  // A pulse arriving with its own grant cancels out; a saturated counter drops the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      ovf_sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pulse[i] && !grant_vec[i]) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else if (!req_pulse[i] && grant_vec[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | ovf_new;
    end
  end

endmodule
